dma_priority_resolver: RTL and testbench

//  4-channel DMA request arbiter for the 8237A-class controller. Combines DREQ pins,

---
 rtl/dma_priority_resolver_pkg.sv | 23 ++
 rtl/dma_priority_resolver_if.sv | 28 ++
 rtl/dma_priority_resolver_encoder.sv | 33 +++
 rtl/dma_priority_resolver.sv | 156 +++++++++++++++
 tb/tb_dma_priority_resolver.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dma_priority_resolver_pkg.sv
// Shared types and constants for the 8237A-class DMA priority resolver.
// Holds the FSM state type, commandReg bit positions and the channel count.
package dma_pkg;

  localparam int NUM_CH = 4;
  localparam int CH_W   = 2;

  localparam int CMD_DISABLE_BIT   = 2;
  localparam int CMD_ROTATE_BIT    = 4;
  localparam int CMD_DREQ_LOW_BIT  = 6;
  localparam int CMD_DACK_HIGH_BIT = 7;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    HOLD_REQ = 2'd1,
    ACTIVE   = 2'd2
  } pr_state_t;

  function automatic logic [NUM_CH-1:0] ch_onehot(input logic [CH_W-1:0] ch);
    return NUM_CH'(1) << ch;
  endfunction

endpackage

// File: rtl/dma_priority_resolver_if.sv
// Request/grant bundle between register block, CPU hold handshake, timing control
// and the priority resolver. The resolver uses the slave modport.
interface dma_priority_resolver_if;
  import dma_pkg::*;

  logic [NUM_CH-1:0] DREQ;
  logic              HLDA;
  logic              serviceDone;
  logic [7:0]        commandReg;
  logic [7:0]        requestReg;
  logic [7:0]        maskReg;
  logic              HRQ;
  logic [NUM_CH-1:0] DACK;
  logic [CH_W-1:0]   activeCh;
  logic              chValid;
  logic [NUM_CH-1:0] swReqClr;

  modport master (
    output DREQ, HLDA, serviceDone, commandReg, requestReg, maskReg,
    input  HRQ, DACK, activeCh, chValid, swReqClr
  );

  modport slave (
    input  DREQ, HLDA, serviceDone, commandReg, requestReg, maskReg,
    output HRQ, DACK, activeCh, chValid, swReqClr
  );

endinterface

// File: rtl/dma_priority_resolver_encoder.sv
// Combinational winner search for the DMA priority resolver (module dma_pri_encoder).
// Fixed mode searches from channel 0; rotating mode starts at pri_ptr and wraps 3->0.
module dma_pri_encoder
  import dma_pkg::*;
(
  input  logic [NUM_CH-1:0] req,
  input  logic [CH_W-1:0]   pri_ptr,
  input  logic              rotate,
  output logic [CH_W-1:0]   winner,
  output logic              any
);

  logic [CH_W-1:0] base;
  logic [CH_W-1:0] idx;
  logic            found;

  // NOTE: every signal written here gets a value before any branch, so no latch can be inferred.
  always_comb begin
    base   = rotate ? pri_ptr : '0;
    winner = base;
    idx    = base;
    found  = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      idx = base + CH_W'(k);
      if (!found && req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
    any = |req;
  end

endmodule

// File: rtl/dma_priority_resolver.sv
// 4-channel DMA request arbiter: request qualification, HRQ/HLDA hold FSM and registered grant.
// Optional build macro DMA_PRI_DREQ_SYNC_EN inserts a 2-flop synchronizer on the DREQ pins.
module dma_priority_resolver
  import dma_pkg::*;
(
  input  logic                    CLK,
  input  logic                    RESET,
  dma_priority_resolver_if.slave  bus
);

  logic [NUM_CH-1:0] dreq_eff;

`ifdef DMA_PRI_DREQ_SYNC_EN
  logic [NUM_CH-1:0] dreq_meta_q, dreq_meta_d;
  logic [NUM_CH-1:0] dreq_sync_q, dreq_sync_d;

  always_comb begin
    dreq_meta_d = bus.DREQ;
    dreq_sync_d = dreq_meta_q;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      dreq_meta_q <= '0;
      dreq_sync_q <= '0;
    end else begin
      dreq_meta_q <= dreq_meta_d;
      dreq_sync_q <= dreq_sync_d;
    end
  end

  assign dreq_eff = dreq_sync_q;
`else
  assign dreq_eff = bus.DREQ;
`endif

  // Request qualification: mask applies to pins only, software requests bypass it.
  logic [NUM_CH-1:0] req;

  always_comb begin
    req = ((dreq_eff ^ {NUM_CH{bus.commandReg[CMD_DREQ_LOW_BIT]}}) & ~bus.maskReg[NUM_CH-1:0])
        | bus.requestReg[NUM_CH-1:0];
    if (bus.commandReg[CMD_DISABLE_BIT]) begin
      req = '0;
    end
  end

  pr_state_t         state_q, state_d;
  logic [CH_W-1:0]   pri_ptr_q, pri_ptr_d;
  logic              hrq_q, hrq_d;
  logic [CH_W-1:0]   active_ch_q, active_ch_d;
  logic              ch_valid_q, ch_valid_d;
  logic [NUM_CH-1:0] sw_req_clr_q, sw_req_clr_d;

  logic [CH_W-1:0]   winner;
  logic              any_req;

  dma_pri_encoder u_encoder (
    .req     (req),
    .pri_ptr (pri_ptr_q),
    .rotate  (bus.commandReg[CMD_ROTATE_BIT]),
    .winner  (winner),
    .any     (any_req)
  );

  always_comb begin
    state_d      = state_q;
    pri_ptr_d    = pri_ptr_q;
    hrq_d        = hrq_q;
    active_ch_d  = active_ch_q;
    ch_valid_d   = ch_valid_q;
    sw_req_clr_d = '0;

    unique case (state_q)
      IDLE: begin
        hrq_d      = 1'b0;
        ch_valid_d = 1'b0;
        // A lingering HLDA from the previous hold must clear before a new request.
        if (any_req && !bus.HLDA) begin
          state_d = HOLD_REQ;
          hrq_d   = 1'b1;
        end
      end

      HOLD_REQ: begin
        if (!any_req) begin
          state_d = IDLE;
          hrq_d   = 1'b0;
        end else if (bus.HLDA) begin
          state_d     = ACTIVE;
          active_ch_d = winner;
          ch_valid_d  = 1'b1;
        end
      end

      ACTIVE: begin
        // serviceDone wins over a simultaneous HLDA drop; grant is never preempted.
        if (bus.serviceDone) begin
          state_d    = IDLE;
          hrq_d      = 1'b0;
          ch_valid_d = 1'b0;
          pri_ptr_d  = active_ch_q + CH_W'(1);
          if (bus.requestReg[active_ch_q]) begin
            sw_req_clr_d = ch_onehot(active_ch_q);
          end
        end else if (!bus.HLDA) begin
          state_d    = IDLE;
          hrq_d      = 1'b0;
          ch_valid_d = 1'b0;
        end
      end

      default: begin
        state_d    = IDLE;
        hrq_d      = 1'b0;
        ch_valid_d = 1'b0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments; RESET is sampled on the clock edge.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q      <= IDLE;
      pri_ptr_q    <= '0;
      hrq_q        <= 1'b0;
      active_ch_q  <= '0;
      ch_valid_q   <= 1'b0;
      sw_req_clr_q <= '0;
    end else begin
      state_q      <= state_d;
      pri_ptr_q    <= pri_ptr_d;
      hrq_q        <= hrq_d;
      active_ch_q  <= active_ch_d;
      ch_valid_q   <= ch_valid_d;
      sw_req_clr_q <= sw_req_clr_d;
    end
  end

  logic [NUM_CH-1:0] dack_int;

  always_comb begin
    dack_int = ch_onehot(active_ch_q) & {NUM_CH{ch_valid_q}};
    bus.DACK = bus.commandReg[CMD_DACK_HIGH_BIT] ? dack_int : ~dack_int;
  end

  assign bus.HRQ      = hrq_q;
  assign bus.activeCh = active_ch_q;
  assign bus.chValid  = ch_valid_q;
  assign bus.swReqClr = sw_req_clr_q;

  logic unused_bits;
  assign unused_bits = ^{bus.commandReg[5], bus.commandReg[3], bus.commandReg[1:0],
                         bus.requestReg[7:NUM_CH], bus.maskReg[7:NUM_CH]};

endmodule

// File: tb/tb_dma_priority_resolver.sv
// Self-checking bench for dma_priority_resolver: directed scenarios plus randomized traffic,
// all outputs compared every cycle against a behavioural hold/grant model.
module tb_dma_priority_resolver;
  import dma_pkg::*;

`ifdef DMA_PRI_DREQ_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif

  logic CLK = 1'b0;
  logic RESET;
  always #5 CLK = ~CLK;

  dma_priority_resolver_if bus ();

  dma_priority_resolver dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
  endtask

  // Stimulus applied on the next tick.
  logic [3:0] s_dreq;
  logic       s_hlda, s_sd, s_rst;
  logic [7:0] s_cmd, s_reqr, s_mask;

  // Behavioural model: hold requested, grant held, granted channel, rotation base.
  bit         m_hrq, m_granted;
  int         m_ch, m_ptr;
  logic [3:0] m_swclr;
  logic [3:0] m_s1, m_s2;

  function automatic int pick(input logic [3:0] r, input int base);
    for (int k = 0; k < 4; k++) begin
      if (r[(base + k) % 4]) return (base + k) % 4;
    end
    return 0;
  endfunction

  task automatic model_edge();
    logic [3:0] seen, r;
    seen = (SYNC_LAT != 0) ? m_s2 : s_dreq;
    if (s_rst) begin
      m_hrq = 0; m_granted = 0; m_ch = 0; m_ptr = 0; m_swclr = '0; m_s1 = '0; m_s2 = '0;
      return;
    end
    r = '0;
    if (!s_cmd[2]) begin
      for (int i = 0; i < 4; i++)
        r[i] = (!s_mask[i] && (seen[i] != s_cmd[6])) || s_reqr[i];
    end
    m_s2 = m_s1;
    m_s1 = s_dreq;
    m_swclr = '0;
    if (m_granted) begin
      if (s_sd) begin
        m_swclr   = s_reqr[m_ch] ? 4'(1 << m_ch) : 4'b0;
        m_ptr     = (m_ch + 1) % 4;
        m_granted = 0;
        m_hrq     = 0;
      end else if (!s_hlda) begin
        m_granted = 0;
        m_hrq     = 0;
      end
    end else if (m_hrq) begin
      if (r == 0) m_hrq = 0;
      else if (s_hlda) begin
        m_ch      = pick(r, s_cmd[4] ? m_ptr : 0);
        m_granted = 1;
      end
    end else if (r != 0 && !s_hlda) begin
      m_hrq = 1;
    end
  endtask

  task automatic tick();
    logic [3:0] exp_dack;
    bus.DREQ        = s_dreq;
    bus.HLDA        = s_hlda;
    bus.serviceDone = s_sd;
    bus.commandReg  = s_cmd;
    bus.requestReg  = s_reqr;
    bus.maskReg     = s_mask;
    RESET           = s_rst;
    @(posedge CLK);
    model_edge();
    #1;
    exp_dack = m_granted ? 4'(1 << m_ch) : 4'b0;
    if (!s_cmd[7]) exp_dack = ~exp_dack;
    check("hrq", bus.HRQ, m_hrq);
    check("chvalid", bus.chValid, m_granted);
    check("dack", bus.DACK, exp_dack);
    check("swreqclr", bus.swReqClr, m_swclr);
    if (m_granted) check("activech", bus.activeCh, m_ch);
  endtask

  task automatic defaults();
    s_dreq = '0; s_hlda = 0; s_sd = 0; s_rst = 0;
    s_cmd = '0; s_reqr = '0; s_mask = '0;
  endtask

  task automatic do_reset();
    defaults();
    s_rst = 1;
    tick();
    s_rst = 0;
  endtask

  task automatic wait_hrq(input string tag);
    for (int i = 0; i < 12; i++) begin
      if (bus.HRQ === 1'b1) return;
      tick();
    end
    check({tag, "_hrq_timeout"}, bus.HRQ, 1);
  endtask

  task automatic wait_valid(input string tag);
    for (int i = 0; i < 12; i++) begin
      if (bus.chValid === 1'b1) return;
      tick();
    end
    check({tag, "_valid_timeout"}, bus.chValid, 1);
  endtask

  task automatic grant_one(input string tag, input int exp_ch);
    s_hlda = 0;
    wait_hrq(tag);
    s_hlda = 1;
    wait_valid(tag);
    check(tag, bus.activeCh, exp_ch);
    s_sd = 1;
    tick();
    s_sd = 0;
    s_hlda = 0;
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    defaults();
    s_rst = 1;
    #1;
    tick();
    tick();
    check("rst_hrq", bus.HRQ, 0);
    check("rst_chvalid", bus.chValid, 0);
    check("rst_dack", bus.DACK, 4'hF);
    check("rst_activech", bus.activeCh, 0);
    check("rst_swreqclr", bus.swReqClr, 0);
    s_rst = 0;

    // Fixed priority, active-high pins, HLDA after 3 cycles.
    s_dreq = 4'b1010;
    repeat (SYNC_LAT) tick();
    check("t1_hrq_before", bus.HRQ, 0);
    tick();
    check("t1_hrq_latency", bus.HRQ, 1);
    tick();
    tick();
    s_hlda = 1;
    tick();
    check("t1_dack", bus.DACK, 4'b1101);
    check("t1_activech", bus.activeCh, 1);
    s_sd = 1;
    tick();
    s_sd = 0;
    check("t1_done_dack", bus.DACK, 4'hF);
    check("t1_done_hrq", bus.HRQ, 0);
    s_hlda = 0;
    s_dreq = '0;
    repeat (4) tick();

    // Active-low pins, then active-high DACK.
    do_reset();
    s_cmd = 8'h40;
    s_dreq = 4'b0101;
    wait_hrq("t1l");
    s_hlda = 1;
    wait_valid("t1l");
    check("t1l_dack_low", bus.DACK, 4'b1101);
    s_cmd = 8'hC0;
    tick();
    check("t1l_dack_high", bus.DACK, 4'b0010);
    s_sd = 1;
    tick();
    do_reset();

    // Rotating priority with all channels requesting.
    s_cmd = 8'h10;
    s_dreq = 4'hF;
    for (int k = 0; k < 5; k++) grant_one($sformatf("t2_grant%0d", k), k % 4);

    // Masked pin, then software request bypassing the mask.
    do_reset();
    s_mask = 8'h01;
    s_dreq = 4'h1;
    repeat (4 + SYNC_LAT) tick();
    check("t3_masked_hrq", bus.HRQ, 0);
    s_reqr = 8'h01;
    wait_hrq("t3");
    s_hlda = 1;
    wait_valid("t3");
    check("t3_activech", bus.activeCh, 0);
    s_sd = 1;
    tick();
    check("t3_swclr", bus.swReqClr, 4'b0001);
    s_sd = 0;
    s_reqr = '0;
    tick();
    check("t3_swclr_end", bus.swReqClr, 4'b0000);
    s_hlda = 0;
    tick();

    // Request withdrawn before HLDA.
    do_reset();
    s_dreq = 4'h4;
    wait_hrq("t4w");
    s_dreq = '0;
    repeat (1 + SYNC_LAT) tick();
    check("t4_withdraw_hrq", bus.HRQ, 0);
    check("t4_withdraw_dack", bus.DACK, 4'hF);

    // HLDA dropped during ACTIVE: abort without rotating.
    s_cmd = 8'h10;
    s_dreq = 4'hF;
    wait_hrq("t4a");
    s_hlda = 1;
    wait_valid("t4a");
    check("t4_first_ch", bus.activeCh, 0);
    s_hlda = 0;
    tick();
    check("t4_abort_valid", bus.chValid, 0);
    check("t4_abort_dack", bus.DACK, 4'hF);
    grant_one("t4_regrant", 0);

    // Controller disabled mid-grant: grant completes, no new hold.
    s_hlda = 0;
    wait_hrq("t5");
    s_hlda = 1;
    wait_valid("t5");
    check("t5_activech", bus.activeCh, 1);
    s_cmd = 8'h14;
    tick();
    tick();
    check("t5_disabled_valid", bus.chValid, 1);
    s_sd = 1;
    tick();
    s_sd = 0;
    s_hlda = 0;
    check("t5_done_hrq", bus.HRQ, 0);
    repeat (5) tick();
    check("t5_disabled_nohrq", bus.HRQ, 0);

    // Reset in the middle of a grant.
    s_cmd = 8'h10;
    wait_hrq("t5r");
    s_hlda = 1;
    wait_valid("t5r");
    s_rst = 1;
    tick();
    check("t5_rst_hrq", bus.HRQ, 0);
    check("t5_rst_valid", bus.chValid, 0);
    check("t5_rst_dack", bus.DACK, 4'hF);
    s_rst = 0;
    s_hlda = 0;

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      if (i % 50 == 0)
        s_cmd = (8'($urandom) & 8'hD0) | (($urandom_range(0, 9) == 0) ? 8'h04 : 8'h00);
      s_dreq = 4'($urandom);
      s_mask = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
      s_reqr = ($urandom_range(0, 5) == 0) ? 8'($urandom_range(0, 15)) : 8'h00;
      s_hlda = m_hrq ? ($urandom_range(0, 11) != 0) : ($urandom_range(0, 7) == 0);
      s_sd   = ($urandom_range(0, 3) == 0);
      s_rst  = ($urandom_range(0, 199) == 0);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
